vga_timing_gen: RTL

Raster timing source for the 800x600 @ 60 Hz display path (40 MHz pixel clock, 1056 x 628 total raster). It produces the pixel position counters, sync pulses, blanking flags and a frame-start strobe consumed by the drawing pipeline. Its vs/hs outputs are the timing reference that frame-capture logic in simulation aligns to. All outputs are registered and describe the same pixel in the same cycle.

---
 rtl/vga_timing_gen_if.sv | 19 +
 rtl/vga_timing_gen.sv | 99 +++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from vga_timing_gen to the drawing pipeline
interface vga_timing_gen_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );

    modport slave (
        input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster position counters, sync, blanking and frame strobe
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic                en,
    vga_timing_gen_if.master    vid
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS      = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_q;
    logic [10:0] vcount_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        hblnk_q;
    logic        vblnk_q;
    logic        frame_start_q;
    logic [15:0] frame_cnt_q;

    logic        h_last;
    logic        v_last;
    logic        frame_wrap;
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        hs_act_nxt;
    logic        vs_act_nxt;

    // Flags are derived from the next counter values so they land on the same edge as the counters.
    always_comb begin
        h_last     = (hcount_q == H_LAST);
        v_last     = (vcount_q == V_LAST);
        frame_wrap = h_last && v_last;
        h_nxt      = h_last ? 11'd0 : hcount_q + 11'd1;
        if (h_last) begin
            v_nxt = v_last ? 11'd0 : vcount_q + 11'd1;
        end else begin
            v_nxt = vcount_q;
        end
        hs_act_nxt = (h_nxt >= HS_START) && (h_nxt < HS_END);
        vs_act_nxt = (v_nxt >= VS_START) && (v_nxt < VS_END);
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else if (en) begin
            hcount_q      <= h_nxt;
            vcount_q      <= v_nxt;
            hsync_q       <= hs_act_nxt ? SYNC_POL : ~SYNC_POL;
            vsync_q       <= vs_act_nxt ? SYNC_POL : ~SYNC_POL;
            hblnk_q       <= (h_nxt >= H_VIS);
            vblnk_q       <= (v_nxt >= V_VIS);
            frame_start_q <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end else begin
            // The strobe is never stretched across a stall.
            frame_start_q <= 1'b0;
        end
    end

    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.hblnk       = hblnk_q;
    assign vid.vblnk       = vblnk_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;

endmodule
